// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundle of requester, response and ALU-side signals around the
//               two-requester ALU arbiter. The slave modport is the arbiter;
//               the master modport is its environment (requesters and ALU).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
    // Requester 0
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [2:0] req0_op;
    logic       req0_ready;
    // Requester 1
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [2:0] req1_op;
    logic       req1_ready;
    // Responses
    logic [1:0] rsp_valid;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    // Shared ALU
    logic [7:0] alu_input_a;
    logic [7:0] alu_input_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_out;
    logic       zero;
    // Status
    logic       busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_out, zero,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_result, rsp_zero,
        output alu_input_a, alu_input_b, alu_opcode,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_out, zero,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_result, rsp_zero,
        input  alu_input_a, alu_input_b, alu_opcode,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter and two-stage issue pipeline in front of
//               a shared combinational 8-bit ALU. Stage 1 registers the granted
//               operands/opcode onto the ALU inputs; stage 2 captures the ALU
//               result and strobes it back to the issuing requester.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int PRIORITY_MODE = 0   // 0 = round-robin, 1 = requester 0 fixed priority
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_arbiter_if.slave  bus
);

    localparam logic [1:0] c_RSP_NONE = 2'b00;
    localparam logic [1:0] c_RSP_REQ0 = 2'b01;
    localparam logic [1:0] c_RSP_REQ1 = 2'b10;

    // Grant signals
    logic       w_tie_pick1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_accept;

    // Stage 1 state
    logic       s1_valid_q,   s1_valid_d;
    logic       s1_id_q,      s1_id_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] alu_a_q,      alu_a_d;
    logic [7:0] alu_b_q,      alu_b_d;
    logic [2:0] alu_op_q,     alu_op_d;

    // Stage 2 state
    logic [1:0] rsp_valid_q,  rsp_valid_d;
    logic [7:0] rsp_result_q, rsp_result_d;
    logic       rsp_zero_q,   rsp_zero_d;

    // Tie-break choice: fixed mode always favours requester 0, round-robin
    // favours whichever requester did not win last.
    generate
        if (PRIORITY_MODE == 1) begin : g_fixed_prio
            assign w_tie_pick1 = 1'b0;
        end else begin : g_round_robin
            assign w_tie_pick1 = ~last_grant_q;
        end
    endgenerate

    // Combinational grant; readies are suppressed while reset is asserted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_gnt0 = ~w_tie_pick1;
                w_gnt1 =  w_tie_pick1;
            end else begin
                w_gnt0 = bus.req0_valid;
                w_gnt1 = bus.req1_valid;
            end
        end
    end

    assign w_accept = w_gnt0 | w_gnt1;

    // Next-state for both pipeline stages; holding registers default to hold.
    always_comb begin
        s1_valid_d   = w_accept;
        s1_id_d      = s1_id_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = c_RSP_NONE;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        if (w_accept) begin
            s1_id_d      = w_gnt1;
            last_grant_d = w_gnt1;
            alu_a_d      = w_gnt1 ? bus.req1_a  : bus.req0_a;
            alu_b_d      = w_gnt1 ? bus.req1_b  : bus.req0_b;
            alu_op_d     = w_gnt1 ? bus.req1_op : bus.req0_op;
        end

        if (s1_valid_q) begin
            rsp_valid_d  = s1_id_q ? c_RSP_REQ1 : c_RSP_REQ0;
            rsp_result_d = bus.alu_out;
            rsp_zero_d   = bus.zero;
        end
    end

    // Pipeline registers; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_op_q     <= 3'b000;
            rsp_valid_q  <= c_RSP_NONE;
            rsp_result_q <= 8'h00;
            rsp_zero_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign bus.req0_ready  = w_gnt0;
    assign bus.req1_ready  = w_gnt1;
    assign bus.alu_input_a = alu_a_q;
    assign bus.alu_input_b = alu_b_q;
    assign bus.alu_opcode  = alu_op_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.busy        = s1_valid_q | (|rsp_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter. One instance in
//               round-robin mode, one in fixed-priority mode, each driving a
//               small behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    alu_arbiter_if if0 ();
    alu_arbiter_if if1 ();

    alu_arbiter #(.PRIORITY_MODE(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    alu_arbiter #(.PRIORITY_MODE(1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Behavioural ALU shared by both instances
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a + b;
            3'b010:  return a ^ b;
            3'b011:  return (a < b) ? 8'h01 : 8'h00;
            3'b100:  return a << b;
            3'b101:  return a >> b;
            3'b110:  return a - b;
            default: return a | b;
        endcase
    endfunction

    assign if0.alu_out = alu_f(if0.alu_input_a, if0.alu_input_b, if0.alu_opcode);
    assign if0.zero    = (if0.alu_out == 8'h00);
    assign if1.alu_out = alu_f(if1.alu_input_a, if1.alu_input_b, if1.alu_opcode);
    assign if1.zero    = (if1.alu_out == 8'h00);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        if0.req0_valid = 1'b0; if0.req0_a = 8'h00; if0.req0_b = 8'h00; if0.req0_op = 3'b000;
        if0.req1_valid = 1'b0; if0.req1_a = 8'h00; if0.req1_b = 8'h00; if0.req1_op = 3'b000;
        if1.req0_valid = 1'b0; if1.req0_a = 8'h00; if1.req0_b = 8'h00; if1.req0_op = 3'b000;
        if1.req1_valid = 1'b0; if1.req1_a = 8'h00; if1.req1_b = 8'h00; if1.req1_op = 3'b000;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_reqs();
        #12;
        if0.req0_valid = 1'b1;
        if0.req1_valid = 1'b1;
        #1;
        n_total++; if (if0.req0_ready !== 1'b0 || if0.req1_ready !== 1'b0)
            $display("FAIL reset_ready: got %b%b exp 00", if0.req1_ready, if0.req0_ready); else n_pass++;
        n_total++; if (if0.rsp_valid !== 2'b00 || if0.busy !== 1'b0)
            $display("FAIL reset_rsp: got rsp_valid=%b busy=%b exp 00/0", if0.rsp_valid, if0.busy); else n_pass++;
        n_total++; if ({if0.alu_input_a, if0.alu_input_b, if0.alu_opcode, if0.rsp_result, if0.rsp_zero} !== 28'h0)
            $display("FAIL reset_regs: got a=%h b=%h op=%b res=%h z=%b exp zeros",
                     if0.alu_input_a, if0.alu_input_b, if0.alu_opcode, if0.rsp_result, if0.rsp_zero); else n_pass++;
        clear_reqs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        logic       e0;
        logic [1:0] erv;
        for (int k = 0; k < 9; k++) begin
            if (k < 6) begin
                if0.req0_valid = 1'b1; if0.req0_a = 8'hF0; if0.req0_b = 8'h0F; if0.req0_op = 3'b000;
                if0.req1_valid = 1'b1; if0.req1_a = 8'hAA; if0.req1_b = 8'hAA; if0.req1_op = 3'b010;
            end else begin
                clear_reqs();
            end
            #2;
            if (k < 6) begin
                e0 = ((k % 2) == 0) ? 1'b1 : 1'b0;
                n_total++; if (if0.req0_ready !== e0 || if0.req1_ready !== ~e0)
                    $display("FAIL rr_ready k=%0d: got %b%b exp %b%b", k, if0.req1_ready, if0.req0_ready, ~e0, e0); else n_pass++;
            end
            if (k >= 2 && k < 8) begin
                erv = (((k - 2) % 2) == 0) ? 2'b01 : 2'b10;
                n_total++; if (if0.rsp_valid !== erv || if0.rsp_result !== 8'h00 || if0.rsp_zero !== 1'b1)
                    $display("FAIL rr_rsp k=%0d: got v=%b r=%h z=%b exp v=%b r=00 z=1",
                             k, if0.rsp_valid, if0.rsp_result, if0.rsp_zero, erv); else n_pass++;
            end
            if (k == 8) begin
                n_total++; if (if0.rsp_valid !== 2'b00 || if0.busy !== 1'b0)
                    $display("FAIL rr_drain: got v=%b busy=%b exp 00/0", if0.rsp_valid, if0.busy); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_single_op;
        if0.req0_valid = 1'b1; if0.req0_a = 8'h05; if0.req0_b = 8'h03; if0.req0_op = 3'b001;
        #2;
        n_total++; if (if0.req0_ready !== 1'b1 || if0.req1_ready !== 1'b0)
            $display("FAIL single_ready: got %b%b exp 01", if0.req1_ready, if0.req0_ready); else n_pass++;
        tick();
        clear_reqs();
        n_total++; if (if0.alu_input_a !== 8'h05 || if0.alu_input_b !== 8'h03 || if0.alu_opcode !== 3'b001 || if0.busy !== 1'b1)
            $display("FAIL single_stage1: got a=%h b=%h op=%b busy=%b exp 05 03 001 1",
                     if0.alu_input_a, if0.alu_input_b, if0.alu_opcode, if0.busy); else n_pass++;
        n_total++; if (if0.rsp_valid !== 2'b00)
            $display("FAIL single_early: got v=%b exp 00", if0.rsp_valid); else n_pass++;
        tick();
        n_total++; if (if0.rsp_valid !== 2'b01 || if0.rsp_result !== 8'h08 || if0.rsp_zero !== 1'b0)
            $display("FAIL single_rsp: got v=%b r=%h z=%b exp 01 08 0",
                     if0.rsp_valid, if0.rsp_result, if0.rsp_zero); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0] ta [3];
        logic [7:0] tb_ [3];
        logic [7:0] er [3];
        ta[0] = 8'h01; tb_[0] = 8'h02; er[0] = 8'h03;
        ta[1] = 8'h10; tb_[1] = 8'h20; er[1] = 8'h30;
        ta[2] = 8'hFF; tb_[2] = 8'h01; er[2] = 8'h00;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                if0.req0_valid = 1'b1; if0.req0_a = ta[k]; if0.req0_b = tb_[k]; if0.req0_op = 3'b001;
            end else begin
                clear_reqs();
            end
            #2;
            if (k < 3) begin
                n_total++; if (if0.req0_ready !== 1'b1)
                    $display("FAIL b2b_ready k=%0d: got %b exp 1", k, if0.req0_ready); else n_pass++;
            end
            if (k >= 2) begin
                n_total++; if (if0.rsp_valid !== 2'b01 || if0.rsp_result !== er[k-2] || if0.rsp_zero !== (er[k-2] == 8'h00))
                    $display("FAIL b2b_rsp k=%0d: got v=%b r=%h z=%b exp 01 %h", k,
                             if0.rsp_valid, if0.rsp_result, if0.rsp_zero, er[k-2]); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_fixed_priority;
        for (int k = 0; k < 7; k++) begin
            clear_reqs();
            if (k < 4) begin
                if1.req0_valid = 1'b1; if1.req0_a = 8'h01; if1.req0_b = 8'h01; if1.req0_op = 3'b001;
            end
            if (k < 5) begin
                if1.req1_valid = 1'b1; if1.req1_a = 8'h02; if1.req1_b = 8'h03; if1.req1_op = 3'b100;
            end
            #2;
            if (k < 4) begin
                n_total++; if (if1.req0_ready !== 1'b1 || if1.req1_ready !== 1'b0)
                    $display("FAIL fp_hold k=%0d: got %b%b exp 01", k, if1.req1_ready, if1.req0_ready); else n_pass++;
            end
            if (k == 4) begin
                n_total++; if (if1.req1_ready !== 1'b1 || if1.req0_ready !== 1'b0)
                    $display("FAIL fp_grant1: got %b%b exp 10", if1.req1_ready, if1.req0_ready); else n_pass++;
            end
            if (k >= 2 && k < 6) begin
                n_total++; if (if1.rsp_valid !== 2'b01 || if1.rsp_result !== 8'h02)
                    $display("FAIL fp_rsp0 k=%0d: got v=%b r=%h exp 01 02", k, if1.rsp_valid, if1.rsp_result); else n_pass++;
            end
            if (k == 6) begin
                n_total++; if (if1.rsp_valid !== 2'b10 || if1.rsp_result !== 8'h10 || if1.rsp_zero !== 1'b0)
                    $display("FAIL fp_rsp1: got v=%b r=%h z=%b exp 10 10 0",
                             if1.rsp_valid, if1.rsp_result, if1.rsp_zero); else n_pass++;
            end
            tick();
        end
        clear_reqs();
    endtask

    task automatic test_compare;
        if0.req1_valid = 1'b1; if0.req1_a = 8'h03; if0.req1_b = 8'h07; if0.req1_op = 3'b011;
        #2;
        n_total++; if (if0.req1_ready !== 1'b1)
            $display("FAIL cmp_ready0: got %b exp 1", if0.req1_ready); else n_pass++;
        tick();
        if0.req1_a = 8'h07; if0.req1_b = 8'h07; if0.req1_op = 3'b110;
        #2;
        n_total++; if (if0.req1_ready !== 1'b1 || if0.alu_opcode !== 3'b011)
            $display("FAIL cmp_ready1: got rdy=%b op=%b exp 1 011", if0.req1_ready, if0.alu_opcode); else n_pass++;
        tick();
        clear_reqs();
        n_total++; if (if0.rsp_valid !== 2'b10 || if0.rsp_result !== 8'h01 || if0.rsp_zero !== 1'b0)
            $display("FAIL cmp_slt: got v=%b r=%h z=%b exp 10 01 0", if0.rsp_valid, if0.rsp_result, if0.rsp_zero); else n_pass++;
        tick();
        n_total++; if (if0.rsp_valid !== 2'b10 || if0.rsp_result !== 8'h00 || if0.rsp_zero !== 1'b1)
            $display("FAIL cmp_sub: got v=%b r=%h z=%b exp 10 00 1", if0.rsp_valid, if0.rsp_result, if0.rsp_zero); else n_pass++;
        tick();
    endtask

    task automatic test_reset_midflight;
        // Requester 0 wins here, leaving last_grant = 0 before the reset.
        if0.req0_valid = 1'b1; if0.req0_a = 8'h11; if0.req0_b = 8'h22; if0.req0_op = 3'b001;
        tick();
        if0.req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_total++; if (if0.rsp_valid !== 2'b00 || if0.busy !== 1'b0 || if0.req0_ready !== 1'b0 || if0.req1_ready !== 1'b0)
            $display("FAIL mid_reset: got v=%b busy=%b rdy=%b%b exp 00 0 00",
                     if0.rsp_valid, if0.busy, if0.req1_ready, if0.req0_ready); else n_pass++;
        n_total++; if (if0.alu_input_a !== 8'h00 || if0.alu_opcode !== 3'b000 || if0.rsp_result !== 8'h00)
            $display("FAIL mid_regs: got a=%h op=%b r=%h exp 00 000 00",
                     if0.alu_input_a, if0.alu_opcode, if0.rsp_result); else n_pass++;
        clear_reqs();
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_total++; if (if0.rsp_valid !== 2'b00 || if0.busy !== 1'b0)
                $display("FAIL mid_stale k=%0d: got v=%b busy=%b exp 00 0", k, if0.rsp_valid, if0.busy); else n_pass++;
        end
        if0.req0_valid = 1'b1; if0.req0_a = 8'h05; if0.req0_b = 8'h03; if0.req0_op = 3'b001;
        if0.req1_valid = 1'b1; if0.req1_a = 8'h01; if0.req1_b = 8'h01; if0.req1_op = 3'b001;
        #2;
        n_total++; if (if0.req0_ready !== 1'b1 || if0.req1_ready !== 1'b0)
            $display("FAIL mid_tie: got %b%b exp 01", if0.req1_ready, if0.req0_ready); else n_pass++;
        tick();
        clear_reqs();
        tick();
        tick();
    endtask

    task automatic test_idle;
        if0.req0_valid = 1'b1; if0.req0_a = 8'h40; if0.req0_b = 8'h02; if0.req0_op = 3'b001;
        tick();
        clear_reqs();
        n_total++; if (if0.busy !== 1'b1 || if0.rsp_valid !== 2'b00)
            $display("FAIL idle_s1: got busy=%b v=%b exp 1 00", if0.busy, if0.rsp_valid); else n_pass++;
        tick();
        n_total++; if (if0.rsp_valid !== 2'b01 || if0.rsp_result !== 8'h42 || if0.busy !== 1'b1)
            $display("FAIL idle_last: got v=%b r=%h busy=%b exp 01 42 1", if0.rsp_valid, if0.rsp_result, if0.busy); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++; if (if0.rsp_valid !== 2'b00 || if0.busy !== 1'b0 || if0.rsp_result !== 8'h42)
                $display("FAIL idle_hold k=%0d: got v=%b busy=%b r=%h exp 00 0 42",
                         k, if0.rsp_valid, if0.busy, if0.rsp_result); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_op();
        test_back_to_back();
        test_fixed_priority();
        test_compare();
        test_reset_midflight();
        test_idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and issue pipeline in front of the shared 8-bit ALU (`alu_input_a`, `alu_input_b`, 3-bit `alu_opcode`, `alu_out`, `zero`). It selects one requester per cycle and registers that requester's operands and opcode onto the ALU inputs. One cycle later it captures `alu_out` and `zero` and returns them to the requester that issued the operation. The block sits between the instruction-execute path (requester 0) and the branch/compare path (requester 1), so a single ALU instance serves both.

## Interface
Parameters:
- `PRIORITY_MODE`, default 0. 0 = round-robin; 1 = fixed priority, requester 0 always wins.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_a`, `req0_b`  in  8  requester 0 operands.
- `req0_op`  in  3  requester 0 ALU opcode.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_op`, `req1_ready`  same as requester 0, for requester 1.
- `rsp_valid`  out  2  one-hot result strobe; bit i = result for requester i.
- `rsp_result`  out  8  captured `alu_out`.
- `rsp_zero`  out  1  captured `zero`.
- `alu_input_a`, `alu_input_b`  out  8  registered operands to the ALU.
- `alu_opcode`  out  3  registered opcode to the ALU.
- `alu_out`  in  8  ALU result; combinational from `alu_input_*` and `alu_opcode`.
- `zero`  in  1  ALU zero flag.
- `busy`  out  1  an operation is in stage 1 or stage 2.

## Operation
- **Grant (combinational, cycle N):**
  - Only one `reqX_valid` high: grant that requester.
  - Both high, `PRIORITY_MODE`=0: grant the requester not recorded in `last_grant`.
  - Both high, `PRIORITY_MODE`=1: grant requester 0.
  - Neither high: no grant.
- **Ready:** `reqX_ready` = grant to X. At most one ready per cycle. Ready is never asserted without the matching valid.
- **Acceptance:** `reqX_valid & reqX_ready` at the edge closing cycle N. The requester holds valid and payload until accepted. It may change payload only after acceptance.
- **Stage 1 registers (load on acceptance):**
  - `alu_input_a`/`alu_input_b`/`alu_opcode` <= granted payload.
  - `s1_valid` <= 1, `s1_id` <= granted index.
  - `last_grant` <= granted index.
- **Stage 1, no acceptance:** `s1_valid` <= 0. The ALU input registers hold their previous values, which are don't-care to consumers.
- **Stage 2 registers (every edge):**
  - `rsp_valid` <= `s1_valid` ? one-hot(`s1_id`) : 2'b00.
  - `rsp_result`/`rsp_zero` <= `alu_out`/`zero` when `s1_valid`; otherwise hold.
- **Responses:** no backpressure. `rsp_valid` is a one-cycle strobe per accepted operation. Requesters must sample it in that cycle.
- **Ordering:** responses return in acceptance order. Full throughput is one operation per cycle, interleaved between requesters.
- **`busy`:** `s1_valid | (|rsp_valid)`.
- **Arithmetic/width:** the block does not modify the 8-bit operands or result. Opcode semantics belong to the ALU. All 8 opcodes pass through unchanged.

## Timing
- **Reset (asynchronous, `rst_n` low):**
  - `alu_input_a`=0, `alu_input_b`=0, `alu_opcode`=0.
  - `s1_valid`=0, `s1_id`=0, `rsp_valid`=2'b00, `rsp_result`=0, `rsp_zero`=0, `busy`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
- **During reset:** `req0_ready`/`req1_ready` forced 0.
- **Latency:**
  - Operation accepted at edge E0.
  - ALU evaluates during cycle E0..E1.
  - Result captured at E1.
  - `rsp_valid` high for the cycle E1..E2.
- **Back-to-back:** acceptances on consecutive edges produce `rsp_valid` strobes on consecutive cycles, with `rsp_result` updated each cycle.
- **Round-robin with both valid continuously:** grants strictly alternate, 0,1,0,1,...
- **Round-robin, one requester idle:** the active requester is granted every cycle. `last_grant` still updates.
- **Reset mid-operation:** in-flight stage 1 and stage 2 contents are discarded. No response is produced after `rst_n` rises. Requesters must reissue.
- **Input changes on non-accepting cycles:** a requester changing valid while not ready has no effect on stage registers.

## Test plan
- **Single op:** only requester 0, `req0_a`=8'h05, `req0_b`=8'h03, `req0_op`=3'b001 -> `req0_ready`=1 that cycle; two edges later `rsp_valid`=2'b01, `rsp_result`=8'h08, `rsp_zero`=0.
- **Round-robin contention:** `PRIORITY_MODE`=0; both requesters held valid for 6 cycles from reset. Requester 0: 8'hF0 & 8'h0F, op 000. Requester 1: 8'hAA ^ 8'hAA, op 010. -> ready alternates 0,1,0,1,0,1; each `rsp_result`=8'h00 with `rsp_zero`=1; `rsp_valid` alternates 01,10.
- **Fixed priority:** `PRIORITY_MODE`=1; both requesters valid for 4 cycles, then requester 0 drops -> `req1_ready`=0 for 4 cycles, then `req1_ready`=1 on cycle 5. Requester 1 op: 8'h02 << 8'h03, op 100 -> `rsp_result`=8'h10.
- **Compare passthrough:** requester 1 sends op 011 with 8'h03, 8'h07 -> `rsp_result`=8'h01. Requester 1 then sends op 110 with 8'h07, 8'h07 -> `rsp_result`=8'h00, `rsp_zero`=1.
- **Reset mid-flight:** accept an operation, then drive `rst_n` low before the next edge -> `rsp_valid`=2'b00 immediately, `busy`=0, all outputs at reset values. After release, no stale strobe appears. The first tie goes to requester 0.
- **Idle pipeline:** no requests for 5 cycles after traffic -> `rsp_valid` is 2'b00 every cycle; `busy` falls one cycle after the last strobe; `rsp_result` holds its last value.
